// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl
// Pipeline recovery sequencer behind the execute-stage branch unit.
// - Compares each resolved next-PC against the fetch-time prediction.
// - On a mismatch, holds flush_o high for DRAIN_CYCLES cycles.
// - Then offers the corrected PC to fetch under a valid/ready handshake.
// - Each branch accepted in IDLE produces a one-cycle predictor update.
// Optional feature macro: BRANCH_REDIRECT_STATS_EN adds saturating
// branch and mispredict counters. Without it, both count ports are tied to 0.
//
// Handshake: redirect_valid_o rises in the first REDIRECT cycle and stays high,
// with redirect_pc_o stable, until a rising clock edge sees redirect_ready_i=1.
// redirect_valid_o may not depend on redirect_ready_i. The transfer completes on
// that edge, and redirect_valid_o is low in the following cycle.
// Every output comes straight from a flop, so no input reaches an output
// through logic alone.
module branch_redirect_ctrl #(
  parameter int XLEN         = 64,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            br_valid_i,
  input  logic [XLEN-1:0] br_pc_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_next_pc_i,
  input  logic [XLEN-1:0] pred_next_pc_i,
  input  logic            redirect_ready_i,
  output logic            flush_o,
  output logic            stall_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            bp_update_valid_o,
  output logic [XLEN-1:0] bp_update_pc_o,
  output logic            bp_update_taken_o,
  output logic [XLEN-1:0] bp_update_target_o,
  output logic [31:0]     br_count_o,
  output logic [31:0]     mispred_count_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  // State is kept as a named flop so checkers can bind to it hierarchically.
  state_e state_q, state_d;
  logic [3:0] drain_cnt_q, drain_cnt_d;

  logic            flush_q, flush_d;
  logic            stall_q, stall_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            bp_update_valid_q, bp_update_valid_d;
  logic [XLEN-1:0] bp_update_pc_q, bp_update_pc_d;
  logic            bp_update_taken_q, bp_update_taken_d;
  logic [XLEN-1:0] bp_update_target_q, bp_update_target_d;

  // Branches are accepted only in IDLE. Any branch seen during recovery is on
  // the wrong path.
  logic br_accept;
  logic mispredict;
  assign br_accept  = (state_q == ST_IDLE) && br_valid_i;
  assign mispredict = br_accept && (br_next_pc_i != pred_next_pc_i);

  // State register and drain counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Next-state logic.
  // The counter is loaded with DRAIN_CYCLES-1, so FLUSH lasts DRAIN_CYCLES cycles.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (mispredict) begin
          state_d     = ST_FLUSH;
          drain_cnt_d = 4'(DRAIN_CYCLES - 1);
        end
      end
      ST_FLUSH: begin
        if (drain_cnt_q == 4'd0) begin
          state_d = ST_REDIRECT;
        end else begin
          drain_cnt_d = drain_cnt_q - 4'd1;
        end
      end
      ST_REDIRECT: begin
        if (redirect_valid_q && redirect_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        drain_cnt_d = 4'd0;
      end
    endcase
  end

  // Output logic.
  // Outputs are decoded from the next state, so each registered output lines
  // up with the state it belongs to.
  always_comb begin
    flush_d            = (state_d == ST_FLUSH);
    redirect_valid_d   = (state_d == ST_REDIRECT);
    stall_d            = (state_d != ST_IDLE);
    redirect_pc_d      = mispredict ? br_next_pc_i : redirect_pc_q;
    bp_update_valid_d  = br_accept;
    bp_update_pc_d     = br_accept ? br_pc_i      : bp_update_pc_q;
    bp_update_taken_d  = br_accept ? br_taken_i   : bp_update_taken_q;
    bp_update_target_d = br_accept ? br_next_pc_i : bp_update_target_q;
  end

  // Output registers. Reset clears everything, including any pending redirect.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      flush_q            <= 1'b0;
      stall_q            <= 1'b0;
      redirect_valid_q   <= 1'b0;
      redirect_pc_q      <= '0;
      bp_update_valid_q  <= 1'b0;
      bp_update_pc_q     <= '0;
      bp_update_taken_q  <= 1'b0;
      bp_update_target_q <= '0;
    end else begin
      flush_q            <= flush_d;
      stall_q            <= stall_d;
      redirect_valid_q   <= redirect_valid_d;
      redirect_pc_q      <= redirect_pc_d;
      bp_update_valid_q  <= bp_update_valid_d;
      bp_update_pc_q     <= bp_update_pc_d;
      bp_update_taken_q  <= bp_update_taken_d;
      bp_update_target_q <= bp_update_target_d;
    end
  end

  assign flush_o            = flush_q;
  assign stall_o            = stall_q;
  assign redirect_valid_o   = redirect_valid_q;
  assign redirect_pc_o      = redirect_pc_q;
  assign bp_update_valid_o  = bp_update_valid_q;
  assign bp_update_pc_o     = bp_update_pc_q;
  assign bp_update_taken_o  = bp_update_taken_q;
  assign bp_update_target_o = bp_update_target_q;

`ifdef BRANCH_REDIRECT_STATS_EN
  logic [31:0] br_count_q, br_count_d;
  logic [31:0] mispred_count_q, mispred_count_d;

  // Saturating counters: they stop at all-ones instead of wrapping.
  always_comb begin
    br_count_d      = br_count_q;
    mispred_count_d = mispred_count_q;
    if (br_accept && (br_count_q != 32'hFFFF_FFFF)) begin
      br_count_d = br_count_q + 32'd1;
    end
    if (mispredict && (mispred_count_q != 32'hFFFF_FFFF)) begin
      mispred_count_d = mispred_count_q + 32'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      br_count_q      <= 32'd0;
      mispred_count_q <= 32'd0;
    end else begin
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign br_count_o      = br_count_q;
  assign mispred_count_o = mispred_count_q;
`else
  assign br_count_o      = 32'd0;
  assign mispred_count_o = 32'd0;
`endif

endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Sequences pipeline recovery after branch resolution. Sits after the execute-stage branch unit: compares each resolved next-PC against the fetch-time prediction and, on mismatch, drives a multi-cycle flush of younger stages, then presents a redirect PC to fetch under a valid/ready handshake. Every resolved branch also produces a one-cycle predictor update.

## Interface
- XLEN, 64, address/data width
- DRAIN_CYCLES, 2, cycles `flush_o` is held high; legal range 1..15

- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- br_valid_i  in  1  resolved branch/jump present this cycle
- br_pc_i  in  XLEN  PC of the resolved instruction
- br_taken_i  in  1  resolved taken flag
- br_next_pc_i  in  XLEN  resolved next PC: target if taken, else pc+4
- pred_next_pc_i  in  XLEN  next PC fetch assumed for this instruction
- redirect_ready_i  in  1  fetch accepts the redirect
- flush_o  out  1  kill all instructions younger than the resolved branch
- stall_o  out  1  execute must not present new branches; high whenever the FSM is not IDLE
- redirect_valid_o  out  1  redirect PC valid
- redirect_pc_o  out  XLEN  corrected fetch PC
- bp_update_valid_o  out  1  one-cycle predictor update strobe
- bp_update_pc_o  out  XLEN  PC of the resolved branch
- bp_update_taken_o  out  1  resolved direction
- bp_update_target_o  out  XLEN  resolved next PC
- br_count_o  out  32  resolved-branch count (stats build only)
- mispred_count_o  out  32  mispredict count (stats build only)

## Operation
- Mispredict is defined as `br_valid_i && (br_next_pc_i != pred_next_pc_i)`, compared over the full XLEN bits.
- The FSM has three states: IDLE, FLUSH and REDIRECT.
- **IDLE**
  - Samples `br_valid_i` every cycle.
  - On a mispredict: latch `br_next_pc_i` into the redirect register, load the drain counter with DRAIN_CYCLES-1, and go to FLUSH.
  - A branch that is not mispredicted causes no state change.
- **FLUSH**
  - `flush_o` is 1.
  - The counter decrements each cycle; when it reaches 0, go to REDIRECT.
- **REDIRECT**
  - `redirect_valid_o` is 1 and `redirect_pc_o` holds the latched value, stable until handshake.
  - On `redirect_valid_o && redirect_ready_i`, go to IDLE.
- **Ignored branches:** `br_valid_i` is ignored in FLUSH and REDIRECT. Those instructions are wrong-path: no update and no count.
- **Predictor update:** every `br_valid_i` accepted in IDLE produces `bp_update_valid_o`=1 in the next cycle only. This includes mispredicts. The other `bp_update_*` fields are registered copies of `br_pc_i`, `br_taken_i` and `br_next_pc_i`.
- **Registered outputs:** all outputs are registered; there is no combinational input-to-output path.

## Timing
- **Reset:** asynchronous assertion forces state IDLE, counter 0, and every output to 0, including counters and PCs. It takes effect mid-FLUSH or mid-REDIRECT; any pending redirect is discarded.
- **Latency:** a mispredict sampled at edge N gives:
  - `flush_o`=1 and `stall_o`=1 for cycles N+1 .. N+DRAIN_CYCLES.
  - `redirect_valid_o`=1 from cycle N+DRAIN_CYCLES+1.
- **Handshake:** `redirect_ready_i` is ignored outside REDIRECT; `redirect_ready_i` already high in the first REDIRECT cycle completes the handshake that cycle. In the cycle after the handshake, `redirect_valid_o`=0 and `stall_o`=0, and a new branch can be sampled that same cycle.
- **Minimum spacing:** two back-to-back recoveries are separated by at least DRAIN_CYCLES+2 cycles.
- **Flush/redirect overlap:** `flush_o` and `redirect_valid_o` are never high in the same cycle.
- **DRAIN_CYCLES=1:** FLUSH lasts exactly one cycle.

## Configuration
- Feature macro: `BRANCH_REDIRECT_STATS_EN`.
- **Defined:**
  - `br_count_o` increments on every branch accepted in IDLE.
  - `mispred_count_o` increments on every mispredict accepted in IDLE.
  - Both counters saturate at 0xFFFF_FFFF and are cleared by reset.
- **Undefined:** both ports remain but are tied to 0; no counter flops are synthesized.

## Test plan
- **Correct prediction:** with DRAIN_CYCLES=2, drive `br_valid_i`=1, pc=0x1000, next=0x1004, pred=0x1004 -> no flush; next cycle `bp_update_valid_o`=1, pc=0x1000, taken=0, target=0x1004.
- **Mispredict, fetch ready:** pc=0x2000, taken=1, next=0x2400, pred=0x2004, `redirect_ready_i`=1 -> `flush_o` high for cycles +1 and +2; `redirect_valid_o`=1 with `redirect_pc_o`=0x2400 at cycle +3; IDLE at cycle +4.
- **Fetch backpressure:** same as the previous scenario with `redirect_ready_i` low for 5 cycles -> `redirect_valid_o` and `redirect_pc_o` stay stable and `stall_o` stays 1; extra `br_valid_i` pulses in that window produce no update.
- **Reset mid-recovery:** assert `rst_i` in the second FLUSH cycle -> all outputs 0 immediately; after release, no redirect appears.
- **Stats build:** with `BRANCH_REDIRECT_STATS_EN` defined, send 3 correct and 2 mispredicted branches, honouring `stall_o` -> `br_count_o`=5 and `mispred_count_o`=2; preload `br_count_o` to 0xFFFF_FFFF -> it holds at 0xFFFF_FFFF.
